// File: rtl/serial_lsb_receiver.sv
// Locks onto an alternating 0/1 serial stream, deserializes locked bits LSB-first into WIDTH-bit words
// and counts pattern violations; word latency LOCK_COUNT+1+WIDTH samples, in_valid low simply stalls.
module serial_lsb_receiver #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic             prev, prev_nxt;
  logic             have_prev, have_prev_nxt;
  logic [3:0]       run, run_nxt;
  logic [4:0]       run_inc;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] word_asm;
  logic [WIDTH-1:0] word_out_nxt;
  logic             word_valid_nxt;
  logic [7:0]       err_count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      prev       <= 1'b0;
      have_prev  <= 1'b0;
      run        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      have_prev  <= have_prev_nxt;
      run        <= run_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      word_out   <= word_out_nxt;
      word_valid <= word_valid_nxt;
      err_count  <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    have_prev_nxt  = have_prev;
    run_nxt        = run;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    word_out_nxt   = word_out;
    word_valid_nxt = 1'b0;
    err_count_nxt  = err_count;
    run_inc        = {1'b0, run} + 5'd1;
    word_asm       = shreg;
    word_asm[bit_cnt] = in;

    if (in_valid) begin
      case (state)
        HUNT: begin
          prev_nxt = in;
          if (!have_prev) begin
            have_prev_nxt = 1'b1;
          end else if (in != prev) begin
            // The sample completing lock only seeds prev; it is not a data bit.
            if (run_inc == 5'(LOCK_COUNT)) begin
              state_nxt   = LOCKED;
              run_nxt     = '0;
              bit_cnt_nxt = '0;
              shreg_nxt   = '0;
            end else begin
              run_nxt = run_inc[3:0];
            end
          end else begin
            run_nxt = '0;
          end
        end

        LOCKED: begin
          prev_nxt = in;
          if (in != prev) begin
            if (bit_cnt == CW'(WIDTH - 1)) begin
              word_out_nxt   = word_asm;
              word_valid_nxt = 1'b1;
              bit_cnt_nxt    = '0;
              shreg_nxt      = '0;
            end else begin
              shreg_nxt   = word_asm;
              bit_cnt_nxt = bit_cnt + CW'(1);
            end
          end else begin
            // Violation beats word completion: drop the partial word and rehunt.
            if (err_count != 8'hFF) err_count_nxt = err_count + 8'd1;
            state_nxt   = HUNT;
            run_nxt     = '0;
            bit_cnt_nxt = '0;
            shreg_nxt   = '0;
          end
        end

        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_serial_lsb_receiver.sv
// Directed bench for serial_lsb_receiver with WIDTH=8, LOCK_COUNT=4.
module tb_serial_lsb_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] word_out;
  logic       word_valid;
  logic       locked;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  serial_lsb_receiver #(.WIDTH(8), .LOCK_COUNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle and return just after the edge that sampled it.
  task automatic send(input logic b, input logic v);
    @(negedge clk);
    in       = b;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset    = 1'b1;
    in       = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_word_out"}, 32'(word_out), 32'h0);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    logic b;
    int   k;
    int   j;

    pulse_reset();
    chk_zero("rst");

    // Lock: first sample seeds prev, then four transitions.
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    chk("lock_early", 32'(locked), 32'h0);
    send(1'b0, 1'b1);
    chk("lock", 32'(locked), 32'h1);
    chk("lock_err", 32'(err_count), 32'h0);

    // Two back-to-back words of 1,0,1,0,... -> 0x55 each, pulse only on bit 8.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        send(~i[0], 1'b1);
        chk($sformatf("w55_%0d_vld%0d", w, i), 32'(word_valid), 32'(i == 7));
      end
      chk($sformatf("w55_%0d_dat", w), 32'(word_out), 32'h55);
    end

    // Violation after three bits of a word.
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    chk("viol_locked", 32'(locked), 32'h0);
    chk("viol_err", 32'(err_count), 32'h1);
    chk("viol_vld", 32'(word_valid), 32'h0);
    chk("viol_dat", 32'(word_out), 32'h55);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    chk("relock_early", 32'(locked), 32'h0);
    send(1'b1, 1'b1);
    chk("relock", 32'(locked), 32'h1);

    // prev is now 1, so the next word is 0,1,0,1,... -> 0xAA.
    for (int i = 0; i < 8; i++) begin
      send(i[0], 1'b1);
      chk($sformatf("wAA_vld%0d", i), 32'(word_valid), 32'(i == 7));
    end
    chk("wAA_dat", 32'(word_out), 32'hAA);

    // Gapped stream: in_valid pattern 1,0,0,1; garbage on in during gaps.
    k = 0;
    j = 0;
    while (k < 8) begin
      if ((j % 4 == 0) || (j % 4 == 3)) begin
        b = k[0];
        send(b, 1'b1);
        k++;
        chk($sformatf("gap_vld_q%0d", k), 32'(word_valid), 32'(k == 8));
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0);
        chk($sformatf("gap_idle_j%0d", j), 32'(word_valid), 32'h0);
      end
      j++;
    end
    chk("gap_dat", 32'(word_out), 32'hAA);
    chk("gap_locked", 32'(locked), 32'h1);

    // 260 violation/relock cycles on top of err_count=1; prev stays 1 each round.
    for (int i = 0; i < 260; i++) begin
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      send(1'b1, 1'b1);
      if (i == 252) chk("sat_254", 32'(err_count), 32'd254);
    end
    chk("sat_255", 32'(err_count), 32'd255);
    chk("sat_locked", 32'(locked), 32'h1);

    // Five locked bits, then reset mid-word.
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    pulse_reset();
    chk_zero("mid_rst");

    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    chk("rst_relock_early", 32'(locked), 32'h0);
    send(1'b1, 1'b1);
    chk("rst_relock", 32'(locked), 32'h1);
    for (int i = 0; i < 8; i++) begin
      send(i[0], 1'b1);
      chk($sformatf("rst_w_vld%0d", i), 32'(word_valid), 32'(i == 7));
    end
    chk("rst_w_dat", 32'(word_out), 32'hAA);
    chk("rst_w_err", 32'(err_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
